// File: rtl/seq_alu_if.sv
// Request/result bundle for seq_alu: operands and op select in, results and status out.
interface seq_alu_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rem;
    logic             flag;
    logic             err;
    logic             busy;
    logic             done;

    modport master (
        output start, op_code, a, b,
        input  out, rem, flag, err, busy, done
    );

    modport slave (
        input  start, op_code, a, b,
        output out, rem, flag, err, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub, shift-add multiply, restoring divide.
// Define ALU_ABS_DIFF_EN to make sub return |a-b| instead of the wrapped difference.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    seq_alu_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   dvsr;
    logic [WIDTH-1:0]   drem;
    logic [WIDTH-1:0]   dquo;
    logic [WIDTH-1:0]   drem_nx;
    logic [WIDTH-1:0]   dquo_nx;
    logic [WIDTH:0]     rem_sh;
    logic               accept;
    logic               last;

    function automatic logic one_hot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Returns {flag, out} for the subtract op.
    function automatic logic [WIDTH:0] sub_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef ALU_ABS_DIFF_EN
        if (y > x) return {1'b1, y - x};
        else       return {1'b0, x - y};
`else
        return {1'b0, x} - {1'b0, y};
`endif
    endfunction

    assign accept = (state == IDLE) && bus.start;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        acc_nx = acc + (mplier[0] ? mcand : '0);
        rem_sh = {drem, dquo[WIDTH-1]};
        if (rem_sh >= {1'b0, dvsr}) begin
            drem_nx = WIDTH'(rem_sh - {1'b0, dvsr});
            dquo_nx = {dquo[WIDTH-2:0], 1'b1};
        end else begin
            drem_nx = rem_sh[WIDTH-1:0];
            dquo_nx = {dquo[WIDTH-2:0], 1'b0};
        end
    end

    // Iteration datapath: loaded on accept, advanced one bit per MUL/DIV cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            dvsr   <= bus.b;
            drem   <= '0;
            dquo   <= bus.a;
        end else if (state == MUL) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else if (state == DIV) begin
            drem   <= drem_nx;
            dquo   <= dquo_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.out  <= '0;
            bus.rem  <= '0;
            bus.flag <= 1'b0;
            bus.err  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        cnt      <= '0;
                        if (!one_hot4(bus.op_code) || (bus.op_code[3] && bus.b == '0)) begin
                            bus.out  <= '0;
                            bus.rem  <= '0;
                            bus.flag <= 1'b0;
                            bus.err  <= 1'b1;
                            bus.done <= 1'b1;
                            state    <= FIN;
                        end else if (bus.op_code[0]) begin
                            {bus.flag, bus.out} <= {1'b0, bus.a} + {1'b0, bus.b};
                            bus.rem  <= '0;
                            bus.err  <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= FIN;
                        end else if (bus.op_code[1]) begin
                            {bus.flag, bus.out} <= sub_result(bus.a, bus.b);
                            bus.rem  <= '0;
                            bus.err  <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= FIN;
                        end else if (bus.op_code[2]) begin
                            state <= MUL;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        bus.out  <= acc_nx[WIDTH-1:0];
                        bus.flag <= |acc_nx[2*WIDTH-1:WIDTH];
                        bus.rem  <= '0;
                        bus.err  <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end
                end
                DIV: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        bus.out  <= dquo_nx;
                        bus.rem  <= drem_nx;
                        bus.flag <= 1'b0;
                        bus.err  <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): arithmetic reference model plus directed literal vectors.
module tb_seq_alu;
    localparam int    W = 8;
    localparam longint M = longint'(1) << W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_alu_if #(.WIDTH(W)) alu ();

    seq_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (alu.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input longint exp);
        checks++;
        if (act !== 64'(exp)) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result and latency of one operation, straight from the arithmetic definition.
    function automatic void model_op(input logic [3:0] op, input longint x, input longint y,
                                     output longint o, output longint r, output bit f,
                                     output bit e, output int lat);
        o = 0; r = 0; f = 0; e = 0; lat = 1;
        if ($countones(op) != 1) begin
            e = 1;
        end else if (op[0]) begin
            o = (x + y) % M;
            f = (x + y) >= M;
        end else if (op[1]) begin
`ifdef ALU_ABS_DIFF_EN
            o = (x >= y) ? x - y : y - x;
`else
            o = (x - y + M) % M;
`endif
            f = y > x;
        end else if (op[2]) begin
            o = (x * y) % M;
            f = (x * y) >= M;
            lat = W + 1;
        end else if (y == 0) begin
            e = 1;
        end else begin
            o = x / y;
            r = x % y;
            lat = W + 1;
        end
    endfunction

    bit     m_busy, m_done, m_flag, m_err, p_flag, p_err;
    longint m_out, m_rem, p_out, p_rem;
    int     m_left;

    always @(posedge clk or posedge rst) begin
        int lat;
        if (rst) begin
            m_busy = 0; m_done = 0; m_flag = 0; m_err = 0;
            m_out = 0; m_rem = 0; m_left = 0;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_out = p_out; m_rem = p_rem; m_flag = p_flag; m_err = p_err;
            end
        end else if (alu.start) begin
            model_op(alu.op_code, longint'(alu.a), longint'(alu.b), p_out, p_rem, p_flag, p_err, lat);
            m_busy = 1;
            m_left = lat - 1;
            if (m_left == 0) begin
                m_done = 1; m_out = p_out; m_rem = p_rem; m_flag = p_flag; m_err = p_err;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", alu.busy, m_busy);
            check("done", alu.done, m_done);
            if (m_done || !m_busy) begin
                check("out", alu.out, m_out);
                check("rem", alu.rem, m_rem);
                check("flag", alu.flag, m_flag);
                check("err", alu.err, m_err);
            end
        end
    end

    task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] x,
                          input logic [7:0] y, input longint eo, input longint er,
                          input bit ef, input bit ee, input int elat);
        int waited;
        @(posedge clk); #1;
        alu.start = 1'b1; alu.op_code = op; alu.a = x; alu.b = y;
        @(posedge clk); #1;
        alu.start = 1'b0;
        waited = 0;
        while (!alu.done && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check({name, "_lat"}, waited + 1, elat);
        check({name, "_out"}, alu.out, eo);
        check({name, "_rem"}, alu.rem, er);
        check({name, "_flag"}, alu.flag, ef);
        check({name, "_err"}, alu.err, ee);
    endtask

    initial begin
        int waited;
        int n;
        alu.start = 1'b0; alu.op_code = 4'd0; alu.a = '0; alu.b = '0;
        #12;
        check("rst_out", alu.out, 0);
        check("rst_rem", alu.rem, 0);
        check("rst_flag", alu.flag, 0);
        check("rst_err", alu.err, 0);
        check("rst_busy", alu.busy, 0);
        check("rst_done", alu.done, 0);

        // Start already requested when reset releases: taken on the very next edge.
        alu.start = 1'b1; alu.op_code = 4'b0001; alu.a = 8'd3; alu.b = 8'd4;
        #5 rst = 1'b0;
        @(posedge clk); #1;
        alu.start = 1'b0;
        check("first_done", alu.done, 1);
        check("first_out", alu.out, 7);

        run_op("add_carry", 4'b0001, 8'd200, 8'd100, 44, 0, 1, 0, 1);
        run_op("add_wrap",  4'b0001, 8'd255, 8'd1,   0,  0, 1, 0, 1);
        run_op("add_zero",  4'b0001, 8'd0,   8'd0,   0,  0, 0, 0, 1);
        run_op("mul_hi",    4'b0100, 8'd20,  8'd15,  44, 0, 1, 0, 9);
        run_op("mul_lo",    4'b0100, 8'd12,  8'd10,  120, 0, 0, 0, 9);
        run_op("mul_max",   4'b0100, 8'd255, 8'd255, 1,  0, 1, 0, 9);
        run_op("div",       4'b1000, 8'd200, 8'd7,   28, 4, 0, 0, 9);
        run_op("div_by1",   4'b1000, 8'd255, 8'd1,   255, 0, 0, 0, 9);
        run_op("div_small", 4'b1000, 8'd3,   8'd200, 0,  3, 0, 0, 9);
        run_op("div_zero",  4'b1000, 8'd5,   8'd0,   0,  0, 0, 1, 1);
`ifdef ALU_ABS_DIFF_EN
        run_op("sub_neg",   4'b0010, 8'd5,   8'd9,   4,  0, 1, 0, 1);
`else
        run_op("sub_neg",   4'b0010, 8'd5,   8'd9,   252, 0, 1, 0, 1);
`endif
        run_op("sub_pos",   4'b0010, 8'd9,   8'd5,   4,  0, 0, 0, 1);
        run_op("op_two",    4'b0110, 8'd9,   8'd5,   0,  0, 0, 1, 1);
        run_op("op_none",   4'b0000, 8'd9,   8'd5,   0,  0, 0, 1, 1);

        // Start pulse with new operands while dividing must be ignored.
        @(posedge clk); #1;
        alu.start = 1'b1; alu.op_code = 4'b1000; alu.a = 8'd200; alu.b = 8'd7;
        @(posedge clk); #1;
        alu.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        alu.start = 1'b1; alu.op_code = 4'b0001; alu.a = 8'd1; alu.b = 8'd1;
        @(posedge clk); #1;
        alu.start = 1'b0;
        waited = 0;
        while (!alu.done && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ign_lat", waited, 5);
        check("ign_out", alu.out, 28);
        check("ign_rem", alu.rem, 4);

        // Reset in the middle of a divide: outputs clear at once and nothing completes.
        @(posedge clk); #1;
        alu.start = 1'b1; alu.op_code = 4'b1000; alu.a = 8'd200; alu.b = 8'd7;
        @(posedge clk); #1;
        alu.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_out", alu.out, 0);
        check("abort_rem", alu.rem, 0);
        check("abort_busy", alu.busy, 0);
        check("abort_done", alu.done, 0);
        check("abort_err", alu.err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (alu.done) n++;
        end
        check("abort_no_resume", n, 0);

        // Start held high: back-to-back adds, one result every two cycles.
        @(posedge clk); #1;
        alu.start = 1'b1; alu.op_code = 4'b0001; alu.a = 8'd1; alu.b = 8'd1;
        n = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (alu.done) begin
                n++;
                check("b2b_out", alu.out, 2);
            end
        end
        alu.start = 1'b0;
        check("b2b_pulses", n, 5);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
